// File: rtl/regfile_pkg.sv
// Shared types and constants for the register file and its writeback stage.
// Build with REGFILE_WR2_EN defined to add the second write port (wr1_*).
package regfile_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;

  // Level the writeback stage drives on wr_en / wr1_en to request a write.
  localparam logic WR_ENABLE = 1'b1;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one flop per register, set on issue, cleared on writeback.
// Produces raw pending bits for two read addresses; bypass masking is done by the caller.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bulk_clr,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr0_en,
  input  logic [ADDR_W-1:0] clr0_addr,
  input  logic              clr1_en,
  input  logic [ADDR_W-1:0] clr1_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              pend_raw_a,
  output logic              pend_raw_b
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_next;

  // Bulk clear beats everything; an issue beats a same-cycle writeback.
  always_comb begin
    pending_next = pending;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bulk_clr) begin
        pending_next[i] = 1'b0;
      end else if (set_en && int'(set_addr) == i) begin
        pending_next[i] = 1'b1;
      end else if ((clr0_en && int'(clr0_addr) == i) ||
                   (clr1_en && int'(clr1_addr) == i)) begin
        pending_next[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  always_comb begin
    pend_raw_a = 1'b0;
    pend_raw_b = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(rd_addr_a) == i) pend_raw_a = pending[i];
      if (int'(rd_addr_b) == i) pend_raw_b = pending[i];
    end
  end

endmodule

// File: rtl/regfile_scb.sv
// Register file with two bypassed read ports, pending-write scoreboard and a sequenced clear.
// Optional second write port (wr1_*) is present only when REGFILE_WR2_EN is defined.
module regfile_scb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = 1 << ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
`ifdef REGFILE_WR2_EN
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
`endif
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              pend_a,
  output logic              pend_b,
  input  logic              clr_req,
  output logic              clr_busy
);

  logic [DATA_W-1:0] rf [NUM_REGS];

  clr_state_e        state;
  clr_state_e        state_next;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] clr_cnt_next;

  logic              idle;
  logic              w0_ok;
  logic              w1_ok;
  logic              w1_req;
  logic [ADDR_W-1:0] w1_addr;
  logic [DATA_W-1:0] w1_data;
  logic              issue_ok;
  logic              bulk_clr;

  logic [ADDR_W-1:0] rd_addr  [2];
  logic [DATA_W-1:0] rd_data  [2];
  logic              pend_raw [2];
  logic              pend     [2];

  // Register 0 is never a real destination when hardwired to zero.
  function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
    return (int'(a) < NUM_REGS) && !(ZERO_REG && (a == '0));
  endfunction

`ifdef REGFILE_WR2_EN
  assign w1_req  = (wr1_en == WR_ENABLE);
  assign w1_addr = wr1_addr;
  assign w1_data = wr1_data;
`else
  assign w1_req  = 1'b0;
  assign w1_addr = '0;
  assign w1_data = '0;
`endif

  assign idle     = (state == ST_IDLE);
  assign w0_ok    = idle && (wr_en == WR_ENABLE) && addr_legal(wr_addr);
  assign w1_ok    = idle && w1_req && addr_legal(w1_addr);
  assign issue_ok = idle && issue_en && addr_legal(issue_addr);
  assign bulk_clr = idle && clr_req;
  assign clr_busy = !idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    case (state)
      ST_IDLE: begin
        if (clr_req) begin
          state_next   = ST_CLEAR;
          clr_cnt_next = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt == ADDR_W'(NUM_REGS - 1)) begin
          state_next   = ST_IDLE;
          clr_cnt_next = '0;
        end else begin
          clr_cnt_next = clr_cnt + 1'b1;
        end
      end
      default: begin
        state_next   = ST_IDLE;
        clr_cnt_next = '0;
      end
    endcase
  end

  // Port 1 is applied last so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf[i] <= '0;
      end
    end else if (!idle) begin
      rf[clr_cnt] <= '0;
    end else begin
      if (w0_ok) rf[wr_addr] <= wr_data;
      if (w1_ok) rf[w1_addr] <= w1_data;
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .bulk_clr   (bulk_clr),
    .set_en     (issue_ok),
    .set_addr   (issue_addr),
    .clr0_en    (w0_ok),
    .clr0_addr  (wr_addr),
    .clr1_en    (w1_ok),
    .clr1_addr  (w1_addr),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .pend_raw_a (pend_raw[0]),
    .pend_raw_b (pend_raw[1])
  );

  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;

  // A bypassed read is resolved this cycle, so it must not also report pending.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      pend[p]    = 1'b0;
      if (idle) begin
        if (w1_ok && (w1_addr == rd_addr[p])) begin
          rd_data[p] = w1_data;
        end else if (w0_ok && (wr_addr == rd_addr[p])) begin
          rd_data[p] = wr_data;
        end else if (addr_legal(rd_addr[p])) begin
          rd_data[p] = rf[rd_addr[p]];
          pend[p]    = pend_raw[p];
        end
      end
    end
  end

  assign rd_data_a = rd_data[0];
  assign rd_data_b = rd_data[1];
  assign pend_a    = pend[0];
  assign pend_b    = pend[1];

endmodule

// File: tb/tb_regfile_scb.sv
// Self-checking bench for regfile_scb: expectations are queued when stimulus is driven
// and popped when the DUT output is sampled on the falling edge.
module tb_regfile_scb;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 8;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr1_en;
  logic [ADDR_W-1:0] wr1_addr;
  logic [DATA_W-1:0] wr1_data;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_addr;
  logic              pend_a;
  logic              pend_b;
  logic              clr_req;
  logic              clr_busy;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] exp_v;
  logic [DATA_W-1:0] model_rf [NREGS];

  regfile_scb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
`ifdef REGFILE_WR2_EN
    .wr1_en     (wr1_en),
    .wr1_addr   (wr1_addr),
    .wr1_data   (wr1_data),
`endif
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .pend_a     (pend_a),
    .pend_b     (pend_b),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    issue_en = 1'b0; issue_addr = '0; clr_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    rd_addr_a = '0; rd_addr_b = '0;
    for (int i = 0; i < NREGS; i++) model_rf[i] = '0;
    repeat (2) @(negedge clk);
    for (int a = 0; a < NREGS; a++) begin
      rd_addr_a = ADDR_W'(a); rd_addr_b = ADDR_W'(a);
      exp_q.push_back('0); exp_q.push_back('0);
      #1;
      exp_v = exp_q.pop_front(); checks++;
      if (rd_data_a !== exp_v) begin errors++; $display("[TB] FAIL reset_rd_a[%0d]: got %h expected %h", a, rd_data_a, exp_v); end
      exp_v = exp_q.pop_front(); checks++;
      if ({15'b0, pend_b} !== exp_v) begin errors++; $display("[TB] FAIL reset_pend_b[%0d]: got %h expected %h", a, pend_b, exp_v); end
    end
    exp_q.push_back('0);
    exp_v = exp_q.pop_front(); checks++;
    if ({15'b0, clr_busy} !== exp_v) begin errors++; $display("[TB] FAIL reset_busy: got %h expected %h", clr_busy, exp_v); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_bypass();
    tick();
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234; rd_addr_a = 3'd3;
    exp_q.push_back(16'h1234);
    model_rf[3] = 16'h1234;
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data_a !== exp_v) begin errors++; $display("[TB] FAIL bypass_same_cycle: got %h expected %h", rd_data_a, exp_v); end
    tick();
    wr_en = 1'b0;
    exp_q.push_back(model_rf[3]);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data_a !== exp_v) begin errors++; $display("[TB] FAIL bypass_stored: got %h expected %h", rd_data_a, exp_v); end
  endtask

  task automatic test_zero_reg();
    tick();
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF; rd_addr_a = 3'd0;
    exp_q.push_back('0);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data_a !== exp_v) begin errors++; $display("[TB] FAIL zero_write_cycle: got %h expected %h", rd_data_a, exp_v); end
    tick();
    wr_en = 1'b0; issue_en = 1'b1; issue_addr = 3'd0;
    exp_q.push_back('0);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data_a !== exp_v) begin errors++; $display("[TB] FAIL zero_after_write: got %h expected %h", rd_data_a, exp_v); end
    tick();
    issue_en = 1'b0;
    exp_q.push_back('0);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if ({15'b0, pend_a} !== exp_v) begin errors++; $display("[TB] FAIL zero_pend: got %h expected %h", pend_a, exp_v); end
  endtask

  task automatic test_scoreboard();
    tick();
    issue_en = 1'b1; issue_addr = 3'd5; rd_addr_b = 3'd5;
    tick();
    issue_en = 1'b0;
    exp_q.push_back(16'd1);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if ({15'b0, pend_b} !== exp_v) begin errors++; $display("[TB] FAIL sb_issue_pend: got %h expected %h", pend_b, exp_v); end
    tick();
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h00AA;
    model_rf[5] = 16'h00AA;
    exp_q.push_back(16'd0); exp_q.push_back(16'h00AA);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if ({15'b0, pend_b} !== exp_v) begin errors++; $display("[TB] FAIL sb_bypass_pend: got %h expected %h", pend_b, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data_b !== exp_v) begin errors++; $display("[TB] FAIL sb_bypass_data: got %h expected %h", rd_data_b, exp_v); end
    tick();
    wr_en = 1'b0;
    exp_q.push_back(16'd0);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if ({15'b0, pend_b} !== exp_v) begin errors++; $display("[TB] FAIL sb_cleared: got %h expected %h", pend_b, exp_v); end
    tick();
    issue_en = 1'b1; issue_addr = 3'd5;
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h00BB;
    model_rf[5] = 16'h00BB;
    tick();
    idle_inputs();
    exp_q.push_back(16'd1); exp_q.push_back(16'h00BB);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if ({15'b0, pend_b} !== exp_v) begin errors++; $display("[TB] FAIL sb_set_wins: got %h expected %h", pend_b, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data_b !== exp_v) begin errors++; $display("[TB] FAIL sb_set_wins_data: got %h expected %h", rd_data_b, exp_v); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] d;
    for (int r = 1; r < NREGS; r++) begin
      tick();
      d = DATA_W'($urandom_range(1, 65535));
      wr_en = 1'b1; wr_addr = ADDR_W'(r); wr_data = d;
      rd_addr_a = ADDR_W'(r); rd_addr_b = ADDR_W'(r - 1);
      exp_q.push_back(d); exp_q.push_back(model_rf[r - 1]);
      model_rf[r] = d;
      @(negedge clk);
      exp_v = exp_q.pop_front(); checks++;
      if (rd_data_a !== exp_v) begin errors++; $display("[TB] FAIL b2b_bypass[%0d]: got %h expected %h", r, rd_data_a, exp_v); end
      exp_v = exp_q.pop_front(); checks++;
      if (rd_data_b !== exp_v) begin errors++; $display("[TB] FAIL b2b_prev[%0d]: got %h expected %h", r, rd_data_b, exp_v); end
    end
    tick();
    wr_en = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      rd_addr_a = ADDR_W'(r);
      exp_q.push_back(model_rf[r]);
      @(negedge clk);
      exp_v = exp_q.pop_front(); checks++;
      if (rd_data_a !== exp_v) begin errors++; $display("[TB] FAIL b2b_readback[%0d]: got %h expected %h", r, rd_data_a, exp_v); end
      tick();
    end
  endtask

  task automatic test_clear();
    int busy_cycles;
    tick();
    issue_en = 1'b1; issue_addr = 3'd6;
    tick();
    issue_en = 1'b0; clr_req = 1'b1; rd_addr_a = 3'd7; rd_addr_b = 3'd6;
    exp_q.push_back(16'd1);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if ({15'b0, pend_b} !== exp_v) begin errors++; $display("[TB] FAIL clr_pre_pend: got %h expected %h", pend_b, exp_v); end
    tick();
    clr_req = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!clr_busy) break;
      busy_cycles++;
      exp_q.push_back('0); exp_q.push_back('0);
      exp_v = exp_q.pop_front(); checks++;
      if (rd_data_a !== exp_v) begin errors++; $display("[TB] FAIL clr_rd_masked[%0d]: got %h expected %h", c, rd_data_a, exp_v); end
      exp_v = exp_q.pop_front(); checks++;
      if ({15'b0, pend_b} !== exp_v) begin errors++; $display("[TB] FAIL clr_pend_masked[%0d]: got %h expected %h", c, pend_b, exp_v); end
      wr_en = (busy_cycles == 5); wr_addr = 3'd2; wr_data = 16'h5555;
      issue_en = (busy_cycles == 5); issue_addr = 3'd4;
      clr_req = (busy_cycles == 5);
    end
    idle_inputs();
    for (int i = 0; i < NREGS; i++) model_rf[i] = '0;
    exp_q.push_back(16'd8);
    exp_v = exp_q.pop_front(); checks++;
    if (DATA_W'(busy_cycles) !== exp_v) begin errors++; $display("[TB] FAIL clr_duration: got %0d expected %0d", busy_cycles, exp_v); end
    for (int r = 0; r < NREGS; r++) begin
      tick();
      rd_addr_a = ADDR_W'(r); rd_addr_b = ADDR_W'(r);
      exp_q.push_back(model_rf[r]); exp_q.push_back('0);
      @(negedge clk);
      exp_v = exp_q.pop_front(); checks++;
      if (rd_data_a !== exp_v) begin errors++; $display("[TB] FAIL clr_after_rd[%0d]: got %h expected %h", r, rd_data_a, exp_v); end
      exp_v = exp_q.pop_front(); checks++;
      if ({15'b0, pend_b} !== exp_v) begin errors++; $display("[TB] FAIL clr_after_pend[%0d]: got %h expected %h", r, pend_b, exp_v); end
    end
  endtask

  task automatic test_reset_mid_clear();
    int busy_cycles;
    bit hit;
    tick();
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h7777;
    tick();
    wr_addr = 3'd3; wr_data = 16'hBEEF;
    tick();
    wr_en = 1'b0; issue_en = 1'b1; issue_addr = 3'd1;
    tick();
    issue_en = 1'b0; clr_req = 1'b1; rd_addr_a = 3'd7; rd_addr_b = 3'd1;
    tick();
    clr_req = 1'b0;
    busy_cycles = 0;
    hit = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!clr_busy) break;
      busy_cycles++;
      if (busy_cycles == 4) begin
        #2 rst_n = 1'b0;
        #1;
        hit = 1'b1;
        exp_q.push_back('0); exp_q.push_back('0);
        exp_v = exp_q.pop_front(); checks++;
        if ({15'b0, clr_busy} !== exp_v) begin errors++; $display("[TB] FAIL rst_mid_busy: got %h expected %h", clr_busy, exp_v); end
        exp_v = exp_q.pop_front(); checks++;
        if (rd_data_a !== exp_v) begin errors++; $display("[TB] FAIL rst_mid_rd: got %h expected %h", rd_data_a, exp_v); end
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin errors++; $display("[TB] FAIL rst_mid_reached: got %0d busy cycles expected at least 4", busy_cycles); end
    for (int i = 0; i < NREGS; i++) model_rf[i] = '0;
    for (int r = 0; r < NREGS; r++) begin
      tick();
      rd_addr_a = ADDR_W'(r); rd_addr_b = ADDR_W'(r);
      exp_q.push_back(model_rf[r]); exp_q.push_back('0);
      @(negedge clk);
      exp_v = exp_q.pop_front(); checks++;
      if (rd_data_a !== exp_v) begin errors++; $display("[TB] FAIL rst_after_rd[%0d]: got %h expected %h", r, rd_data_a, exp_v); end
      exp_v = exp_q.pop_front(); checks++;
      if ({15'b0, pend_b} !== exp_v) begin errors++; $display("[TB] FAIL rst_after_pend[%0d]: got %h expected %h", r, pend_b, exp_v); end
    end
    tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    exp_q.push_back(16'd1);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if ({15'b0, clr_busy} !== exp_v) begin errors++; $display("[TB] FAIL rst_new_clr: got %h expected %h", clr_busy, exp_v); end
    busy_cycles = 1;
    for (int c = 0; c < 20 && clr_busy; c++) begin
      @(negedge clk);
      if (clr_busy) busy_cycles++;
    end
    exp_q.push_back(16'd8);
    exp_v = exp_q.pop_front(); checks++;
    if (DATA_W'(busy_cycles) !== exp_v) begin errors++; $display("[TB] FAIL rst_new_clr_len: got %0d expected %0d", busy_cycles, exp_v); end
  endtask

`ifdef REGFILE_WR2_EN
  task automatic test_wr2();
    tick();
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h1111;
    wr1_en = 1'b1; wr1_addr = 3'd4; wr1_data = 16'h2222;
    rd_addr_a = 3'd4;
    model_rf[4] = 16'h2222;
    exp_q.push_back(16'h2222);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data_a !== exp_v) begin errors++; $display("[TB] FAIL wr2_bypass: got %h expected %h", rd_data_a, exp_v); end
    tick();
    idle_inputs();
    issue_en = 1'b1; issue_addr = 3'd6; rd_addr_b = 3'd6;
    exp_q.push_back(model_rf[4]);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data_a !== exp_v) begin errors++; $display("[TB] FAIL wr2_stored: got %h expected %h", rd_data_a, exp_v); end
    tick();
    issue_en = 1'b0; wr1_en = 1'b1; wr1_addr = 3'd6; wr1_data = 16'h0606;
    tick();
    wr1_en = 1'b0;
    exp_q.push_back(16'd0);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if ({15'b0, pend_b} !== exp_v) begin errors++; $display("[TB] FAIL wr2_clears_pend: got %h expected %h", pend_b, exp_v); end
  endtask
`endif

  initial begin
    test_reset();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
`ifdef REGFILE_WR2_EN
    test_wr2();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
